draw_bg_scroll: RTL and testbench

Parametrised, horizontally scrolling background renderer, successor to the fixed-scale static background drawer.
- Maps each VGA pixel to a source image coordinate using a configurable fixed-point scale.
- Adds a per-frame scroll offset that wraps modulo the image width, and fetches the pixel from an external synchronous image ROM.
- Outputs the VGA timing delayed to match the pixel, so downstream draw stages stay aligned.

---
 rtl/bg_pkg.sv | 22 ++
 rtl/vga_if.sv | 12 +
 rtl/bg_scroll_ctr.sv | 47 ++++
 rtl/draw_bg_scroll.sv | 107 ++++++++++
 tb/tb_draw_bg_scroll.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/bg_pkg.sv
// Shared defaults and types for the scrolling background renderer.
package bg_pkg;

  localparam int unsigned DEF_IMG_W       = 320;
  localparam int unsigned DEF_IMG_H       = 240;
  localparam int unsigned DEF_ADDR_W      = 17;
  localparam int unsigned DEF_SCALE_NUM   = 5;
  localparam int unsigned DEF_SCALE_SHIFT = 4;

  typedef logic [11:0] rgb12_t;
  localparam rgb12_t BLACK = 12'h000;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
  } vga_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between draw stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk);
endinterface

// File: rtl/bg_scroll_ctr.sv
// Per-frame horizontal scroll offset, kept modulo IMG_W, advanced on the vblnk rising edge.
module bg_scroll_ctr
  import bg_pkg::*;
#(
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned SPEED_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vblnk,
  input  logic                       scroll_en,
  input  logic [SPEED_W-1:0]         scroll_speed,
  input  logic                       scroll_clr,
  output logic [$clog2(IMG_W)-1:0]   offset
);

  localparam int unsigned OFF_W = $clog2(IMG_W);

  logic             r_vblnk_d;
  logic [OFF_W-1:0] r_offset;
  logic             w_tick;
  logic [OFF_W:0]   w_sum;
  logic [OFF_W:0]   w_wrap;

  assign w_tick = vblnk & ~r_vblnk_d;

  // speed < IMG_W, so one conditional subtraction keeps the sum in range
  always_comb begin
    w_sum  = (OFF_W+1)'(r_offset) + (OFF_W+1)'(scroll_speed);
    w_wrap = w_sum;
    if (w_sum >= (OFF_W+1)'(IMG_W)) w_wrap = w_sum - (OFF_W+1)'(IMG_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_d <= 1'b0;
      r_offset  <= '0;
    end else begin
      r_vblnk_d <= vblnk;
      if (scroll_clr)                r_offset <= '0;
      else if (w_tick && scroll_en)  r_offset <= OFF_W'(w_wrap);
    end
  end

  assign offset = r_offset;

endmodule

// File: rtl/draw_bg_scroll.sv
// Scaled, horizontally scrolling background fetch from an external image ROM,
// with VGA timing delayed to line up with the returned pixel.
module draw_bg_scroll
  import bg_pkg::*;
#(
  parameter int unsigned IMG_W       = DEF_IMG_W,
  parameter int unsigned IMG_H       = DEF_IMG_H,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned SCALE_NUM   = DEF_SCALE_NUM,
  parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int unsigned ROM_LAT     = 1,
  parameter int unsigned SPEED_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  vga_if.in                  vin,
  vga_if.out                 vout,
  input  logic               scroll_en,
  input  logic [SPEED_W-1:0] scroll_speed,
  input  logic               scroll_clr,
  output logic [ADDR_W-1:0]  rom_addr,
  input  rgb12_t             rom_data,
  output rgb12_t             rgb_bg
);

  localparam int unsigned LAT    = 2 + ROM_LAT;
  localparam int unsigned OFF_W  = $clog2(IMG_W);
  localparam int unsigned PROD_W = 11 + $clog2(SCALE_NUM + 1);
  localparam int unsigned MAX_SX = ((2**11 - 1) * SCALE_NUM) >> SCALE_SHIFT;
  localparam int unsigned RED_N  = MAX_SX / IMG_W + 1;

  typedef struct packed {
    logic vld;
    vga_t t;
  } dly_t;

  vga_t              w_vin;
  logic [OFF_W-1:0]  w_offset;
  logic [PROD_W-1:0] r_sx;
  logic [PROD_W-1:0] r_sy;
  logic [31:0]       w_xw;
  logic [31:0]       w_syc;
  logic [ADDR_W-1:0] w_addr;
  dly_t              r_dly [LAT];
  dly_t              w_out;

  assign w_vin = {vin.vcount, vin.vsync, vin.vblnk, vin.hcount, vin.hsync, vin.hblnk};

  bg_scroll_ctr #(
    .IMG_W   (IMG_W),
    .SPEED_W (SPEED_W)
  ) u_ctr (
    .clk          (clk),
    .rst          (rst),
    .vblnk        (vin.vblnk),
    .scroll_en    (scroll_en),
    .scroll_speed (scroll_speed),
    .scroll_clr   (scroll_clr),
    .offset       (w_offset)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sx <= '0;
      r_sy <= '0;
    end else begin
      r_sx <= (PROD_W'(vin.hcount) * PROD_W'(SCALE_NUM)) >> SCALE_SHIFT;
      r_sy <= (PROD_W'(vin.vcount) * PROD_W'(SCALE_NUM)) >> SCALE_SHIFT;
    end
  end

  // Bounded unrolled subtraction covers sx beyond IMG_W plus the added offset
  always_comb begin
    w_xw = 32'(r_sx) + 32'(w_offset);
    for (int unsigned i = 0; i < RED_N; i++) begin
      if (w_xw >= IMG_W) w_xw = w_xw - IMG_W;
    end
    w_syc  = (32'(r_sy) > IMG_H - 1) ? IMG_H - 1 : 32'(r_sy);
    w_addr = ADDR_W'(w_syc * IMG_W + w_xw);
  end

  always_ff @(posedge clk) begin
    if (rst) rom_addr <= '0;
    else     rom_addr <= w_addr;
  end

  // vld marks slots filled since reset so stale ROM data is never shown
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= {1'b1, w_vin};
      for (int unsigned i = 1; i < LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign w_out       = r_dly[LAT-1];
  assign vout.vcount = w_out.t.vcount;
  assign vout.vsync  = w_out.t.vsync;
  assign vout.vblnk  = w_out.t.vblnk;
  assign vout.hcount = w_out.t.hcount;
  assign vout.hsync  = w_out.t.hsync;
  assign vout.hblnk  = w_out.t.hblnk;

  assign rgb_bg = (!w_out.vld || w_out.t.vblnk || w_out.t.hblnk) ? BLACK : rom_data;

endmodule

// File: tb/tb_draw_bg_scroll.sv
// Scoreboard bench for draw_bg_scroll: default build plus an IMG_H=100, ROM_LAT=2 build on shared stimulus.
module tb_draw_bg_scroll;
  import bg_pkg::*;

  localparam int unsigned W  = 320;
  localparam int unsigned HA = 240;
  localparam int unsigned HB = 100;
  localparam int          LA = 3;
  localparam int          LB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, scroll_en, scroll_clr;
  logic [3:0]  scroll_speed;
  logic [16:0] addr_a, addr_b;
  rgb12_t      rom_a, rom_b, rom_b1, rgb_a, rgb_b;

  vga_if vin_if ();
  vga_if vout_a ();
  vga_if vout_b ();

  always @(posedge clk) begin
    rom_a  <= addr_a[11:0];
    rom_b1 <= addr_b[11:0];
    rom_b  <= rom_b1;
  end

  draw_bg_scroll u_a (
    .clk(clk), .rst(rst), .vin(vin_if), .vout(vout_a),
    .scroll_en(scroll_en), .scroll_speed(scroll_speed), .scroll_clr(scroll_clr),
    .rom_addr(addr_a), .rom_data(rom_a), .rgb_bg(rgb_a)
  );

  draw_bg_scroll #(.IMG_H(100), .ROM_LAT(2)) u_b (
    .clk(clk), .rst(rst), .vin(vin_if), .vout(vout_b),
    .scroll_en(scroll_en), .scroll_speed(scroll_speed), .scroll_clr(scroll_clr),
    .rom_addr(addr_b), .rom_data(rom_b), .rgb_bg(rgb_b)
  );

  typedef struct { int due; vga_t tim; rgb12_t rgb; } oe_t;
  typedef struct { int due; logic [16:0] addr; } ae_t;
  typedef struct { int h; int v; bit hb; int ea; int eb; } vec_t;

  oe_t qoa[$], qob[$];
  ae_t qaa[$], qab[$];
  int  total = 0, bad = 0, cyc = 0;
  int unsigned m_off = 0;
  logic        m_prev = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic vga_t mk(input int h, input int v, input bit hb, input bit vb);
    vga_t t;
    t.hcount = 11'(h);
    t.vcount = 11'(v);
    t.hsync  = t.hcount[0];
    t.vsync  = t.vcount[0];
    t.hblnk  = hb;
    t.vblnk  = vb;
    return t;
  endfunction

  function automatic logic [16:0] model_addr(input int unsigned h, input int unsigned v,
                                             input int unsigned hh, input int unsigned off);
    int unsigned sx, sy;
    sx = (h * 5) >> 4;
    sy = (v * 5) >> 4;
    if (sy > hh - 1) sy = hh - 1;
    return 17'(sy * W + (sx + off) % W);
  endfunction

  task automatic check_due();
    ae_t a;
    oe_t o;
    while (qaa.size() > 0 && qaa[0].due == cyc) begin
      a = qaa.pop_front();
      cmp("addr_a", 32'(addr_a), 32'(a.addr));
    end
    while (qab.size() > 0 && qab[0].due == cyc) begin
      a = qab.pop_front();
      cmp("addr_b", 32'(addr_b), 32'(a.addr));
    end
    while (qoa.size() > 0 && qoa[0].due == cyc) begin
      o = qoa.pop_front();
      cmp("vout_a", 32'({vout_a.vcount, vout_a.vsync, vout_a.vblnk, vout_a.hcount,
                         vout_a.hsync, vout_a.hblnk}), 32'(o.tim));
      cmp("rgb_a", 32'(rgb_a), 32'(o.rgb));
    end
    while (qob.size() > 0 && qob[0].due == cyc) begin
      o = qob.pop_front();
      cmp("vout_b", 32'({vout_b.vcount, vout_b.vsync, vout_b.vblnk, vout_b.hcount,
                         vout_b.hsync, vout_b.hblnk}), 32'(o.tim));
      cmp("rgb_b", 32'(rgb_b), 32'(o.rgb));
    end
  endtask

  // pa/pb >= 0 pin a hand-computed address in place of the model's
  task automatic step(input vga_t t, input logic r, input logic en, input logic clr,
                      input logic [3:0] spd, input int pa, input int pb);
    vga_t        tt;
    logic [16:0] ea, eb;
    logic        tick;
    rst = r; scroll_en = en; scroll_clr = clr; scroll_speed = spd;
    vin_if.vcount = t.vcount; vin_if.vsync = t.vsync; vin_if.vblnk = t.vblnk;
    vin_if.hcount = t.hcount; vin_if.hsync = t.hsync; vin_if.hblnk = t.hblnk;
    if (r) begin
      m_off = 0; m_prev = 1'b0; tt = '0; ea = '0; eb = '0;
      foreach (qoa[i]) begin qoa[i].tim = '0; qoa[i].rgb = BLACK; end
      foreach (qob[i]) begin qob[i].tim = '0; qob[i].rgb = BLACK; end
      foreach (qaa[i]) qaa[i].addr = '0;
      foreach (qab[i]) qab[i].addr = '0;
    end else begin
      tick   = t.vblnk && !m_prev;
      m_prev = t.vblnk;
      if (clr)              m_off = 0;
      else if (tick && en)  m_off = (m_off + spd) % W;
      tt = t;
      ea = (pa >= 0) ? 17'(pa) : model_addr(t.hcount, t.vcount, HA, m_off);
      eb = (pb >= 0) ? 17'(pb) : model_addr(t.hcount, t.vcount, HB, m_off);
    end
    qaa.push_back('{cyc + 2, ea});
    qab.push_back('{cyc + 2, eb});
    qoa.push_back('{cyc + LA, tt, (r || t.vblnk || t.hblnk) ? BLACK : ea[11:0]});
    qob.push_back('{cyc + LB, tt, (r || t.vblnk || t.hblnk) ? BLACK : eb[11:0]});
    @(posedge clk);
    cyc++;
    #1;
    check_due();
  endtask

  task automatic frames(input int n, input logic en, input logic [3:0] spd);
    repeat (n) begin
      repeat (2) step(mk(700, 500, 1, 1), 1'b0, en, 1'b0, spd, -1, -1);
      repeat (2) step(mk(160, 0, 0, 0), 1'b0, en, 1'b0, spd, -1, -1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    tbl[0] = '{160,   32, 1'b0,  3250,  3250};
    tbl[1] = '{0,    400, 1'b1, 40000, 31680};
    tbl[2] = '{639,  479, 1'b0, 47879, 31879};
    tbl[3] = '{1100,   0, 1'b0,    23,    23};
    tbl[4] = '{2047, 2047, 1'b0, 76799, 31999};
    tbl[5] = '{1,     15, 1'b1,  1280,  1280};
    tbl[6] = '{4,     16, 1'b0,  1601,  1601};
    tbl[7] = '{767,  767, 1'b0, 76719, 31919};

    #1;
    repeat (3) step(mk(0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 4'd0, -1, -1);

    // address map, clamp and hblnk alignment at offset 0
    for (int i = 0; i < 8; i++)
      step(mk(tbl[i].h, tbl[i].v, tbl[i].hb, 1'b0), 1'b0, 1'b0, 1'b0, 4'd0, tbl[i].ea, tbl[i].eb);

    // wrap: 20 frames at speed 15 -> 300, then one more -> 315
    step(mk(160, 0, 0, 0), 1'b0, 1'b0, 1'b1, 4'd0, -1, -1);
    frames(20, 1'b1, 4'd15);
    step(mk(160, 0, 0, 0), 1'b0, 1'b1, 1'b0, 4'd15, 30, 30);
    frames(1, 1'b1, 4'd15);
    step(mk(160, 0, 0, 0), 1'b0, 1'b1, 1'b0, 4'd15, 45, 45);

    // priority: speed 3 x5, clr on a tick, disabled frames, zero speed
    step(mk(0, 0, 0, 0), 1'b0, 1'b0, 1'b1, 4'd0, -1, -1);
    frames(5, 1'b1, 4'd3);
    step(mk(0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 4'd3, 15, 15);
    step(mk(700, 500, 1, 1), 1'b0, 1'b1, 1'b1, 4'd3, -1, -1);
    step(mk(0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 4'd3, 0, 0);
    frames(5, 1'b1, 4'd3);
    frames(3, 1'b0, 4'd3);
    step(mk(0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 4'd3, 15, 15);
    frames(2, 1'b1, 4'd0);
    step(mk(0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 4'd0, 15, 15);

    // mixed random traffic against the model
    for (int i = 0; i < 60; i++)
      step(mk($urandom_range(2047), $urandom_range(2047), 1'($urandom_range(1)),
              1'($urandom_range(3) == 0)),
           1'b0, 1'($urandom_range(1)), 1'($urandom_range(15) == 0),
           4'($urandom_range(15)), -1, -1);

    // reset mid-frame with a non-zero offset
    frames(2, 1'b1, 4'd3);
    repeat (2) step(mk(400, 10, 0, 0), 1'b0, 1'b1, 1'b0, 4'd3, -1, -1);
    step(mk(400, 10, 0, 0), 1'b1, 1'b1, 1'b0, 4'd3, -1, -1);
    step(mk(160, 32, 0, 0), 1'b0, 1'b0, 1'b0, 4'd0, 3250, 3250);
    for (int i = 0; i < 8; i++)
      step(mk(tbl[i].h, tbl[i].v, tbl[i].hb, 1'b0), 1'b0, 1'b0, 1'b0, 4'd0, tbl[i].ea, tbl[i].eb);
    repeat (6) step(mk(0, 0, 1, 1), 1'b0, 1'b0, 1'b0, 4'd0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
